// File: rtl/qu_pkg.sv
// Shared types and helpers for the multi-ported renaming register file.
// Entry layout, the "value ready" tag and flat-bus slice helpers live here.
package qu_pkg;

   localparam int QU_RF_WIDTH = 32;
   localparam int QU_QI_WIDTH = 6;

   typedef struct packed {
      logic [QU_QI_WIDTH-1:0] qi;
      logic [QU_RF_WIDTH-1:0] data;
   } rf_entry_t;

   localparam logic [QU_QI_WIDTH-1:0] QI_READY = '0;

   // Low bit of port idx inside a flat bus of w-bit slices.
   function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
      return idx * w;
   endfunction

endpackage

// File: rtl/rf_mp_prio_sel.sv
// Per-register selection of the highest-index enabled write port targeting it.
module rf_mp_prio_sel #(
   parameter  int NUM_P    = 2,
   parameter  int RF_DEPTH = 32,
   localparam int ADDR_W   = $clog2(RF_DEPTH),
   localparam int SEL_W    = (NUM_P > 1) ? $clog2(NUM_P) : 1
) (
   input  logic [NUM_P-1:0]                 en,
   input  logic [NUM_P-1:0][ADDR_W-1:0]     addr,
   output logic [RF_DEPTH-1:0]              hit,
   output logic [RF_DEPTH-1:0][SEL_W-1:0]   sel
);

   // Ascending scan: a later (higher) port overwrites an earlier match.
   always_comb begin
      hit = '0;
      sel = '0;
      for (int r = 0; r < RF_DEPTH; r++) begin
         for (int p = 0; p < NUM_P; p++) begin
            if (en[p] && addr[p] == ADDR_W'(r)) begin
               hit[r] = 1'b1;
               sel[r] = SEL_W'(p);
            end
         end
      end
   end

endmodule

// File: rtl/rf_mp.sv
// Multi-ported register file with per-register producer tags (qi), tag-matched
// commit clearing, global flush and optional commit-to-read bypass.
module rf_mp
   import qu_pkg::*;
#(
   parameter  int RF_WIDTH = QU_RF_WIDTH,
   parameter  int RF_DEPTH = 32,
   parameter  int QI_WIDTH = QU_QI_WIDTH,
   parameter  int NUM_RD   = 4,
   parameter  int NUM_RN   = 2,
   parameter  int NUM_WB   = 2,
   parameter  int BYPASS   = 1,
   localparam int ADDR_W   = $clog2(RF_DEPTH)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_RD*ADDR_W-1:0]     rd_addr,
   output logic [NUM_RD*RF_WIDTH-1:0]   rd_data,
   output logic [NUM_RD*QI_WIDTH-1:0]   rd_qi,
   input  logic [NUM_RN-1:0]            rn_en,
   input  logic [NUM_RN*ADDR_W-1:0]     rn_addr,
   input  logic [NUM_RN*QI_WIDTH-1:0]   rn_qi,
   input  logic [NUM_WB-1:0]            wb_en,
   input  logic [NUM_WB*ADDR_W-1:0]     wb_addr,
   input  logic [NUM_WB*QI_WIDTH-1:0]   wb_qi,
   input  logic [NUM_WB*RF_WIDTH-1:0]   wb_data,
   input  logic                         flush,
   output logic [ADDR_W:0]              pending_cnt
);

   localparam int RN_SW = (NUM_RN > 1) ? $clog2(NUM_RN) : 1;
   localparam int WB_SW = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;
   localparam logic [QI_WIDTH-1:0] QI0 = QI_WIDTH'(QI_READY);

   logic [NUM_RD-1:0][ADDR_W-1:0]   rd_addr_a;
   logic [NUM_RN-1:0][ADDR_W-1:0]   rn_addr_a;
   logic [NUM_RN-1:0][QI_WIDTH-1:0] rn_qi_a;
   logic [NUM_WB-1:0][ADDR_W-1:0]   wb_addr_a;
   logic [NUM_WB-1:0][QI_WIDTH-1:0] wb_qi_a;
   logic [NUM_WB-1:0][RF_WIDTH-1:0] wb_data_a;

   assign rd_addr_a = rd_addr;
   assign rn_addr_a = rn_addr;
   assign rn_qi_a   = rn_qi;
   assign wb_addr_a = wb_addr;
   assign wb_qi_a   = wb_qi;
   assign wb_data_a = wb_data;

   logic [RF_DEPTH-1:0][RF_WIDTH-1:0] data_q, data_n;
   logic [RF_DEPTH-1:0][QI_WIDTH-1:0] qi_q, qi_n;
   logic [RF_DEPTH-1:0]               rn_hit, wb_hit, wb_clr;
   logic [RF_DEPTH-1:0][RN_SW-1:0]    rn_sel;
   logic [RF_DEPTH-1:0][WB_SW-1:0]    wb_sel;
   logic [ADDR_W:0]                   cnt_n;

   rf_mp_prio_sel #(.NUM_P(NUM_RN), .RF_DEPTH(RF_DEPTH)) u_rn_sel (
      .en(rn_en), .addr(rn_addr_a), .hit(rn_hit), .sel(rn_sel)
   );

   rf_mp_prio_sel #(.NUM_P(NUM_WB), .RF_DEPTH(RF_DEPTH)) u_wb_sel (
      .en(wb_en), .addr(wb_addr_a), .hit(wb_hit), .sel(wb_sel)
   );

   // Any commit whose tag matches the pre-cycle qi retires the pending producer.
   always_comb begin
      wb_clr = '0;
      for (int r = 0; r < RF_DEPTH; r++)
         for (int j = 0; j < NUM_WB; j++)
            if (wb_en[j] && wb_addr_a[j] == ADDR_W'(r) && wb_qi_a[j] == qi_q[r])
               wb_clr[r] = 1'b1;
   end

   // x0 is skipped so it keeps its reset value forever.
   always_comb begin
      data_n = data_q;
      qi_n   = qi_q;
      cnt_n  = '0;
      for (int r = 1; r < RF_DEPTH; r++) begin
         if (wb_hit[r]) data_n[r] = wb_data_a[wb_sel[r]];
         if (flush)          qi_n[r] = QI0;
         else if (rn_hit[r]) qi_n[r] = rn_qi_a[rn_sel[r]];
         else if (wb_clr[r]) qi_n[r] = QI0;
      end
      for (int r = 0; r < RF_DEPTH; r++)
         if (qi_n[r] != QI0) cnt_n += (ADDR_W+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q      <= '0;
         qi_q        <= '0;
         pending_cnt <= '0;
      end else begin
         data_q      <= data_n;
         qi_q        <= qi_n;
         pending_cnt <= cnt_n;
      end
   end

   // Reads see pre-rename state; only commits are forwarded.
   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic              byp;
      assign a   = rd_addr_a[i];
      assign byp = (BYPASS != 0) && wb_hit[a];
      assign rd_data[slice_lo(i, RF_WIDTH) +: RF_WIDTH] =
         (a == '0) ? '0 : (byp ? wb_data_a[wb_sel[a]] : data_q[a]);
      assign rd_qi[slice_lo(i, QI_WIDTH) +: QI_WIDTH] =
         ((a == '0) || (byp && wb_qi_a[wb_sel[a]] == qi_q[a])) ? QI0 : qi_q[a];
   end

endmodule

// File: tb/tb_rf_mp.sv
// Directed bench for rf_mp: rename/commit/flush/bypass scenarios with hand-computed expectations.
module tb_rf_mp;

   logic         clk = 1'b0;
   logic         rst;
   logic [19:0]  rd_addr;
   logic [127:0] rd_data;
   logic [23:0]  rd_qi;
   logic [1:0]   rn_en;
   logic [9:0]   rn_addr;
   logic [11:0]  rn_qi;
   logic [1:0]   wb_en;
   logic [9:0]   wb_addr;
   logic [11:0]  wb_qi;
   logic [63:0]  wb_data;
   logic         flush;
   logic [5:0]   pending_cnt;

   int total = 0;
   int bad   = 0;

   rf_mp dut (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_qi(rd_qi),
      .rn_en(rn_en), .rn_addr(rn_addr), .rn_qi(rn_qi),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_qi(wb_qi), .wb_data(wb_data),
      .flush(flush), .pending_cnt(pending_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic rd(input int p, input int a);
      rd_addr[p*5 +: 5] = 5'(a);
   endtask

   function automatic logic [31:0] rdd(input int p);
      return rd_data[p*32 +: 32];
   endfunction

   function automatic logic [5:0] rdq(input int p);
      return rd_qi[p*6 +: 6];
   endfunction

   task automatic rn(input int p, input int a, input int q);
      rn_en[p]          = 1'b1;
      rn_addr[p*5 +: 5] = 5'(a);
      rn_qi[p*6 +: 6]   = 6'(q);
   endtask

   task automatic wb(input int p, input int a, input int q, input logic [31:0] d);
      wb_en[p]           = 1'b1;
      wb_addr[p*5 +: 5]  = 5'(a);
      wb_qi[p*6 +: 6]    = 6'(q);
      wb_data[p*32 +: 32] = d;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      rn_en = '0;
      wb_en = '0;
      flush = 1'b0;
   endtask

   task automatic chk_reg(input string tag, input int a, input logic [31:0] d, input logic [5:0] q);
      rd(3, a);
      #1;
      chk($sformatf("%s.data", tag), 64'(rdd(3)), 64'(d));
      chk($sformatf("%s.qi", tag), 64'(rdq(3)), 64'(q));
   endtask

   task automatic chk_pend(input string tag, input int n);
      chk(tag, 64'(pending_cnt), 64'(n));
   endtask

   initial begin
      rst = 1'b1; rd_addr = '0; rn_en = '0; rn_addr = '0; rn_qi = '0;
      wb_en = '0; wb_addr = '0; wb_qi = '0; wb_data = '0; flush = 1'b0;
      step(); step();
      rst = 1'b0;

      // reset state across every address and every read port
      for (int a = 0; a < 32; a++) begin
         rd(a % 4, a);
         #1;
         chk($sformatf("rst.d%0d", a), 64'(rdd(a % 4)), 64'h0);
         chk($sformatf("rst.q%0d", a), 64'(rdq(a % 4)), 64'h0);
      end
      chk_pend("rst.pend", 0);

      // rename then matching commit
      rn(0, 5, 7); step();
      chk_pend("rn5.pend", 1);
      chk_reg("rn5", 5, 32'h0, 6'd7);
      wb(0, 5, 7, 32'hDEADBEEF); rd(0, 5); #1;
      chk("byp5.data", 64'(rdd(0)), 64'hDEADBEEF);
      chk("byp5.qi", 64'(rdq(0)), 64'h0);
      step();
      chk_pend("wb5.pend", 0);
      chk_reg("wb5", 5, 32'hDEADBEEF, 6'd0);

      // stale commit must not clear a younger producer's tag
      rn(0, 5, 7); step();
      rn(1, 5, 9); step();
      chk_pend("rn9.pend", 1);
      wb(0, 5, 7, 32'h11); rd(0, 5); #1;
      chk("stale.byp.data", 64'(rdd(0)), 64'h11);
      chk("stale.byp.qi", 64'(rdq(0)), 64'd9);
      step();
      chk_reg("stale", 5, 32'h11, 6'd9);
      chk_pend("stale.pend", 1);
      wb(1, 5, 9, 32'h11); step();
      chk_pend("clr9.pend", 0);

      // same-cycle rename and matching commit: rename wins qi, data written
      rn(0, 3, 2); step();
      chk_pend("x3.pend", 1);
      rn(0, 3, 4); wb(1, 3, 2, 32'h55); step();
      chk_reg("rnwb", 3, 32'h55, 6'd4);
      chk_pend("rnwb.pend", 1);

      // flush discards renames, keeps commit data
      rn(0, 1, 1); rn(1, 2, 2); step();
      rn(0, 3, 3); step();
      chk_pend("pre.flush.pend", 3);
      flush = 1'b1; rn(0, 4, 5); wb(1, 6, 0, 32'hAA); step();
      chk_pend("flush.pend", 0);
      chk_reg("flush.x1", 1, 32'h0, 6'd0);
      chk_reg("flush.x2", 2, 32'h0, 6'd0);
      chk_reg("flush.x3", 3, 32'h55, 6'd0);
      chk_reg("flush.x4", 4, 32'h0, 6'd0);
      chk_reg("flush.x6", 6, 32'hAA, 6'd0);

      // bypass on port 2 and x0 immunity
      wb(0, 8, 0, 32'h1234); rd(2, 8); rd(1, 8); #1;
      chk("byp8.p2", 64'(rdd(2)), 64'h1234);
      chk("byp8.p1", 64'(rdd(1)), 64'h1234);
      step();
      chk_reg("x8", 8, 32'h1234, 6'd0);
      rn(0, 0, 3); wb(1, 0, 0, 32'hFF); rd(2, 0); #1;
      chk("x0.byp.data", 64'(rdd(2)), 64'h0);
      chk("x0.byp.qi", 64'(rdq(2)), 64'h0);
      step();
      chk_reg("x0", 0, 32'h0, 6'd0);
      chk_pend("x0.pend", 0);

      // multi-port priority: highest index wins
      wb(0, 10, 0, 32'h1); wb(1, 10, 0, 32'h2); step();
      chk_reg("wbprio", 10, 32'h2, 6'd0);
      rn(0, 11, 6); rn(1, 11, 8); step();
      chk_reg("rnprio", 11, 32'h0, 6'd8);
      chk_pend("rnprio.pend", 1);

      // tag-0 rules
      rn(0, 11, 0); step();
      chk_reg("rn0", 11, 32'h0, 6'd0);
      chk_pend("rn0.pend", 0);
      rn(0, 12, 5); step();
      wb(0, 12, 0, 32'h77); step();
      chk_reg("wbq0", 12, 32'h77, 6'd5);
      chk_pend("wbq0.pend", 1);

      // reset overrides a same-cycle rename
      rst = 1'b1; rn(0, 13, 4); step();
      rst = 1'b0;
      chk_pend("rst2.pend", 0);
      chk_reg("rst2.x12", 12, 32'h0, 6'd0);
      chk_reg("rst2.x13", 13, 32'h0, 6'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
